pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 6, number of pipeline stages; index 0 = PC stage, index NUM_STAGES-1 = last stage.
REQ-002 SHALL have parameter CNT_W, default 6, width of the timed-stall length.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 1, flush pulse length in cycles (>=1).
REQ-004 SHALL have parameter WDOG_W, default 8, stall-watchdog counter width.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port stallreq, input, NUM_STAGES, per-stage stall request, level-sensitive.
REQ-008 SHALL have port timed_req, input, 1, one-cycle pulse starting a fixed-length stall.
REQ-009 SHALL have port timed_stage, input, $clog2(NUM_STAGES), stage owning the timed stall.
REQ-010 SHALL have port timed_len, input, CNT_W, timed-stall length in cycles.
REQ-011 SHALL have port flush_req, input, 1, pipeline flush request (exception/redirect).
REQ-012 SHALL have port flush_pc, input, 32, redirect target sampled with flush_req.
REQ-013 SHALL have port stall, output, NUM_STAGES, per-stage hold vector.
REQ-014 SHALL have port flush, output, 1, registered flush pulse to all stages.
REQ-015 SHALL have port new_pc, output, 32, registered redirect target.
REQ-016 SHALL have port busy, output, 1, high when state is not RUN.
REQ-017 SHALL have port stall_timeout, output, 1, sticky watchdog flag.

Function
REQ-018 SHALL implement states RUN, TIMED, FLUSH.
REQ-019 SHALL compute stall combinationally: k = highest index i with stallreq[i]=1, or with i=timed_stage while a timed stall is active; stall[j]=1 for all j<=k, else 0; no request gives all zeros.
REQ-020 SHALL treat a timed stall as active in the cycle timed_req=1 is accepted and in every TIMED cycle.
REQ-021 SHALL accept timed_req only in RUN with timed_len!=0 and flush_req=0; otherwise ignore it.
REQ-022 SHALL, on acceptance, latch timed_stage, load counter with timed_len-1, enter TIMED if timed_len>1, else stay RUN; total timed stall = exactly timed_len cycles.
REQ-023 SHALL in TIMED return to RUN when counter==1, else decrement; timed_req ignored in TIMED.
REQ-024 SHALL, on flush_req=1 in any state, at next edge enter FLUSH, load new_pc<=flush_pc, load flush counter with FLUSH_CYCLES, abort any timed stall.
REQ-025 SHALL assert flush=1 exactly in FLUSH cycles (FLUSH_CYCLES cycles), then return to RUN.
REQ-026 SHALL force stall to all zeros during FLUSH, ignoring stallreq.
REQ-027 SHALL restart FLUSH with the new flush_pc when flush_req=1 during FLUSH (latest wins).
REQ-028 SHALL give flush_req priority over timed_req when both arrive in the same cycle.
REQ-029 SHALL hold new_pc stable between flushes.
REQ-030 SHALL increment the watchdog counter each cycle stall[0]=1, saturating at 2^WDOG_W-1; clear it when stall[0]=0 or in FLUSH.
REQ-031 SHALL set stall_timeout when the watchdog counter reaches 2^WDOG_W-1; clear it only by rst or by entry to FLUSH.

Reset
REQ-032 SHALL, while rst=1, immediately force: state RUN, all counters 0, stall=0, flush=0, new_pc=0, busy=0, stall_timeout=0.
REQ-033 SHALL abort any TIMED or FLUSH in progress on rst, with no residual pulse after release.

Verification (NUM_STAGES=6, FLUSH_CYCLES=1, WDOG_W=8)
REQ-034 SHALL check stallreq=001000 -> stall=001111; 000100 -> 000111; 001100 -> 001111; 000000 -> 000000.
REQ-035 SHALL check timed_req, timed_stage=3, timed_len=4 -> stall=001111 for exactly 4 cycles including the request cycle, busy=1 for the last 3 of them, then stall=0.
REQ-036 SHALL check flush_req, flush_pc=0xBFC00380 in the 2nd TIMED cycle -> next cycle flush=1, new_pc=0xBFC00380, stall=0; the following cycle RUN, busy=0, no resumed timed stall.
REQ-037 SHALL check stallreq[2] held 300 cycles -> stall_timeout rises when the counter reaches 255, stays high after release, and clears on the next flush.
REQ-038 SHALL check rst pulse mid-TIMED -> stall=0, busy=0, flush=0 in the same cycle, no flush or stall after release.
REQ-039 SHALL check flush_req and timed_req in the same cycle -> FLUSH entered, timed_req ignored, no timed stall afterward.

Source files
------------

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- pipeline hazard / flush controller
//
// Turns per-stage stall requests, a self-timed multi-cycle stall and a flush
// (exception / redirect) request into the hold vector and flush pulse that
// the pipeline stages consume.
//
// A stall at stage k must also hold every older stage (indices 0..k), so the
// hold vector is a "thermometer" running from stage 0 up to the highest
// requesting stage.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   stallreq      : per-stage level stall request (index 0 = PC stage)
//   timed_req     : 1-cycle pulse starting a stall of timed_len cycles
//   timed_stage   : stage that owns the timed stall
//   timed_len     : timed stall length in cycles (0 = no stall)
//   flush_req     : flush request; flush_pc is captured with it
//   flush_pc      : redirect target
//   stall         : per-stage hold vector (combinational)
//   flush         : flush pulse, high for FLUSH_CYCLES cycles
//   new_pc        : registered redirect target, stable between flushes
//   busy          : controller is in TIMED or FLUSH
//   stall_timeout : sticky flag, stage 0 held for 2^WDOG_W-1 cycles
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int NUM_STAGES   = 6,
  parameter int CNT_W        = 6,
  parameter int FLUSH_CYCLES = 1,
  parameter int WDOG_W       = 8,
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq,
  input  logic                  timed_req,
  input  logic [SW-1:0]         timed_stage,
  input  logic [CNT_W-1:0]      timed_len,
  input  logic                  flush_req,
  input  logic [31:0]           flush_pc,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic [31:0]           new_pc,
  output logic                  busy,
  output logic                  stall_timeout
);

  // Flush counter must be able to hold FLUSH_CYCLES itself.
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_TIMED = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]           tstage_q, tstage_d;
  logic [FW-1:0]           fcnt_q, fcnt_d;
  logic [31:0]             new_pc_q, new_pc_d;
  logic [WDOG_W-1:0]       wdog_q, wdog_d;
  logic                    tmo_q, tmo_d;

  logic                    accept;
  logic                    timed_act;
  logic [SW-1:0]           timed_sel;
  logic [NUM_STAGES-1:0]   req_vec;
  logic [NUM_STAGES-1:0]   stall_c;

  // ---------------------------------------------------------------------------
  // Timed-stall acceptance. A flush in the same cycle wins, so the timed
  // request is simply dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    accept    = (state_q == S_RUN) && timed_req && (timed_len != '0) && !flush_req;
    // The stall is already visible in the accepting cycle, using the live
    // stage index; afterwards the latched copy is used.
    timed_act = accept || (state_q == S_TIMED);
    timed_sel = accept ? timed_stage : tstage_q;
  end

  // ---------------------------------------------------------------------------
  // Hold vector: stage j is held if any stage at index >= j requests.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_vec = stallreq;
    if (timed_act)
      req_vec = req_vec | (NUM_STAGES'(1) << timed_sel);
  end

  always_comb begin
    stall_c = '0;
    if (!rst && (state_q != S_FLUSH)) begin
      for (int j = 0; j < NUM_STAGES; j++)
        stall_c[j] = |(req_vec >> j);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tstage_d = tstage_q;
    fcnt_d   = fcnt_q;
    new_pc_d = new_pc_q;

    if (flush_req) begin
      // Any state: (re)start the flush with the newest target and drop any
      // timed stall in progress.
      state_d  = S_FLUSH;
      new_pc_d = flush_pc;
      fcnt_d   = FW'(FLUSH_CYCLES);
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (accept) begin
            tstage_d = timed_stage;
            // The accepting cycle is the first stall cycle, so the counter
            // covers the remaining timed_len-1 cycles.
            cnt_d    = timed_len - 1'b1;
            state_d  = (timed_len > CNT_W'(1)) ? S_TIMED : S_RUN;
          end
        end
        S_TIMED: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_FLUSH: begin
          if (fcnt_q == FW'(1)) begin
            state_d = S_RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - 1'b1;
          end
        end
        default: begin
          state_d = S_RUN;
          cnt_d   = '0;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stall watchdog: counts consecutive cycles with the PC stage held.
  // The timeout flag survives the stall going away so software can see it;
  // only a flush (or reset) clears it.
  // ---------------------------------------------------------------------------
  always_comb begin
    wdog_d = wdog_q;
    if ((state_q == S_FLUSH) || !stall_c[0])
      wdog_d = '0;
    else if (wdog_q != '1)
      wdog_d = wdog_q + 1'b1;

    tmo_d = tmo_q;
    if (flush_req)
      tmo_d = 1'b0;
    else if (wdog_d == '1)
      tmo_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      cnt_q    <= '0;
      tstage_q <= '0;
      fcnt_q   <= '0;
      new_pc_q <= '0;
      wdog_q   <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tstage_q <= tstage_d;
      fcnt_q   <= fcnt_d;
      new_pc_q <= new_pc_d;
      wdog_q   <= wdog_d;
      tmo_q    <= tmo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: everything except the hold vector comes straight from flops.
  // ---------------------------------------------------------------------------
  assign stall         = stall_c;
  assign flush         = (state_q == S_FLUSH);
  assign busy          = (state_q != S_RUN);
  assign new_pc        = new_pc_q;
  assign stall_timeout = tmo_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. The stimulus process drives one cycle at a
// time and queues the outputs it expects for that cycle; a monitor samples
// the DUT on the falling edge and checks against the queue.
module tb_pipe_ctrl;

  localparam int NS = 6;

  logic          clk;
  logic          rst;
  logic [NS-1:0] stallreq;
  logic          timed_req;
  logic [2:0]    timed_stage;
  logic [5:0]    timed_len;
  logic          flush_req;
  logic [31:0]   flush_pc;
  logic [NS-1:0] stall;
  logic          flush;
  logic [31:0]   new_pc;
  logic          busy;
  logic          stall_timeout;

  pipe_ctrl #(
    .NUM_STAGES  (6),
    .CNT_W       (6),
    .FLUSH_CYCLES(1),
    .WDOG_W      (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq     (stallreq),
    .timed_req    (timed_req),
    .timed_stage  (timed_stage),
    .timed_len    (timed_len),
    .flush_req    (flush_req),
    .flush_pc     (flush_pc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .busy         (busy),
    .stall_timeout(stall_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          cyc;
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
    logic        bz;
    logic        to;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare whenever an expectation is due for this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", e.nm, e.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      tests++;
      if (stall !== e.st || flush !== e.fl || new_pc !== e.pc ||
          busy !== e.bz || stall_timeout !== e.to) begin
        fails++;
        $display("FAIL %s: got stall=%b flush=%b new_pc=%h busy=%b tmo=%b, want stall=%b flush=%b new_pc=%h busy=%b tmo=%b",
                 e.nm, stall, flush, new_pc, busy, stall_timeout,
                 e.st, e.fl, e.pc, e.bz, e.to);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string nm, input logic [5:0] st, input logic fl,
                            input logic [31:0] pc, input logic bz, input logic to);
    exp_t e;
    e.cyc = cyc; e.st = st; e.fl = fl; e.pc = pc; e.bz = bz; e.to = to; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic timed(input logic [2:0] stg, input logic [5:0] len);
    timed_req = 1'b1; timed_stage = stg; timed_len = len;
  endtask

  localparam logic [31:0] PC_A = 32'hBFC0_0380;
  localparam logic [31:0] PC_B = 32'h0000_1000;
  localparam logic [31:0] PC_C = 32'h8000_0180;
  localparam logic [31:0] PC_D = 32'h1234_5678;
  localparam logic [31:0] PC_E = 32'hDEAD_BEE0;

  initial begin
    rst = 1'b1; stallreq = '0; timed_req = 1'b0; timed_stage = '0;
    timed_len = '0; flush_req = 1'b0; flush_pc = '0;

    // Reset state, with a stall request present that must be masked.
    step(); stallreq = 6'b001000;
    expect_now("reset", 6'b000000, 0, 32'h0, 0, 0);
    step(); stallreq = '0; rst = 1'b0;
    expect_now("post_rst", 6'b000000, 0, 32'h0, 0, 0);

    // Thermometer decode of level requests.
    step(); stallreq = 6'b001000; expect_now("sr_001000", 6'b001111, 0, 32'h0, 0, 0);
    step(); stallreq = 6'b000100; expect_now("sr_000100", 6'b000111, 0, 32'h0, 0, 0);
    step(); stallreq = 6'b001100; expect_now("sr_001100", 6'b001111, 0, 32'h0, 0, 0);
    step(); stallreq = 6'b100000; expect_now("sr_100000", 6'b111111, 0, 32'h0, 0, 0);
    step(); stallreq = 6'b000001; expect_now("sr_000001", 6'b000001, 0, 32'h0, 0, 0);
    step(); stallreq = 6'b000000; expect_now("sr_none",   6'b000000, 0, 32'h0, 0, 0);

    // Timed stall, stage 3, 4 cycles.
    step(); timed(3'd3, 6'd4);  expect_now("t4_c0", 6'b001111, 0, 32'h0, 0, 0);
    step(); timed_req = 1'b0;   expect_now("t4_c1", 6'b001111, 0, 32'h0, 1, 0);
    step();                     expect_now("t4_c2", 6'b001111, 0, 32'h0, 1, 0);
    step();                     expect_now("t4_c3", 6'b001111, 0, 32'h0, 1, 0);
    step();                     expect_now("t4_end", 6'b000000, 0, 32'h0, 0, 0);

    // Length 1: single cycle, never busy. Length 0: ignored.
    step(); timed(3'd1, 6'd1);  expect_now("t1_c0", 6'b000011, 0, 32'h0, 0, 0);
    step(); timed_req = 1'b0;   expect_now("t1_end", 6'b000000, 0, 32'h0, 0, 0);
    step(); timed(3'd4, 6'd0);  expect_now("t0_c0", 6'b000000, 0, 32'h0, 0, 0);
    step(); timed_req = 1'b0;   expect_now("t0_end", 6'b000000, 0, 32'h0, 0, 0);

    // Timed stall merged with a higher level request; timed_req in TIMED ignored.
    step(); timed(3'd1, 6'd2); stallreq = 6'b010000;
    expect_now("t2_mix", 6'b011111, 0, 32'h0, 0, 0);
    step(); timed(3'd5, 6'd9); stallreq = '0;
    expect_now("t2_c1", 6'b000011, 0, 32'h0, 1, 0);
    step(); timed_req = 1'b0;  expect_now("t2_end", 6'b000000, 0, 32'h0, 0, 0);

    // Flush in the 2nd TIMED cycle aborts the timed stall.
    step(); timed(3'd3, 6'd4);  expect_now("tf_c0", 6'b001111, 0, 32'h0, 0, 0);
    step(); timed_req = 1'b0;   expect_now("tf_c1", 6'b001111, 0, 32'h0, 1, 0);
    step(); flush_req = 1'b1; flush_pc = PC_A;
    expect_now("tf_c2", 6'b001111, 0, 32'h0, 1, 0);
    step(); flush_req = 1'b0; flush_pc = '0;
    expect_now("tf_flush", 6'b000000, 1, PC_A, 1, 0);
    step(); expect_now("tf_run", 6'b000000, 0, PC_A, 0, 0);
    step(); expect_now("tf_idle", 6'b000000, 0, PC_A, 0, 0);

    // Stall requests masked during FLUSH.
    step(); flush_req = 1'b1; flush_pc = PC_B; stallreq = 6'b000100;
    expect_now("fm_req", 6'b000111, 0, PC_A, 0, 0);
    step(); flush_req = 1'b0;
    expect_now("fm_flush", 6'b000000, 1, PC_B, 1, 0);
    step(); stallreq = '0; expect_now("fm_run", 6'b000000, 0, PC_B, 0, 0);

    // Back-to-back flushes: latest target wins.
    step(); flush_req = 1'b1; flush_pc = PC_C;
    expect_now("rf_req1", 6'b000000, 0, PC_B, 0, 0);
    step(); flush_pc = PC_D;
    expect_now("rf_req2", 6'b000000, 1, PC_C, 1, 0);
    step(); flush_req = 1'b0;
    expect_now("rf_flush2", 6'b000000, 1, PC_D, 1, 0);
    step(); expect_now("rf_run", 6'b000000, 0, PC_D, 0, 0);

    // Flush and timed request together: flush wins, no timed stall.
    step(); flush_req = 1'b1; flush_pc = PC_C; timed(3'd3, 6'd4);
    expect_now("ft_req", 6'b000000, 0, PC_D, 0, 0);
    step(); flush_req = 1'b0; timed_req = 1'b0;
    expect_now("ft_flush", 6'b000000, 1, PC_C, 1, 0);
    step(); expect_now("ft_run1", 6'b000000, 0, PC_C, 0, 0);
    step(); expect_now("ft_run2", 6'b000000, 0, PC_C, 0, 0);

    // Reset in the middle of a timed stall.
    step(); timed(3'd2, 6'd10); expect_now("rt_c0", 6'b000111, 0, PC_C, 0, 0);
    step(); timed_req = 1'b0;   expect_now("rt_c1", 6'b000111, 0, PC_C, 1, 0);
    step(); rst = 1'b1;         expect_now("rt_rst", 6'b000000, 0, 32'h0, 0, 0);
    step(); rst = 1'b0;         expect_now("rt_rel", 6'b000000, 0, 32'h0, 0, 0);
    step();                     expect_now("rt_after", 6'b000000, 0, 32'h0, 0, 0);
    step();                     expect_now("rt_after2", 6'b000000, 0, 32'h0, 0, 0);

    // Watchdog: stage 2 held 300 cycles; flag rises once the counter hits 255.
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 1) stallreq = 6'b000100;
      if (i == 1 || i == 254 || i == 255 || i == 256 || i == 300)
        expect_now($sformatf("wd_%0d", i), 6'b000111, 0, 32'h0, 0, (i >= 256));
    end
    step(); stallreq = '0; expect_now("wd_rel", 6'b000000, 0, 32'h0, 0, 1);
    step();                expect_now("wd_hold", 6'b000000, 0, 32'h0, 0, 1);
    step(); flush_req = 1'b1; flush_pc = PC_E;
    expect_now("wd_freq", 6'b000000, 0, 32'h0, 0, 1);
    step(); flush_req = 1'b0;
    expect_now("wd_flush", 6'b000000, 1, PC_E, 1, 0);
    step(); expect_now("wd_clr", 6'b000000, 0, PC_E, 0, 0);

    step();
    step();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
